wb_merge: RTL

//  Write-back merge stage directly upstream of the register file write port.

---
 rtl/wb_merge.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/wb_merge.sv
// wb_merge - write-back merge stage in front of the register file write port.
//
// Merges the in-order pipeline write-back stream with results from long-latency
// units (mul/div, load miss). Aux results are buffered in an in-order FIFO and
// written out whenever the pipeline has no write of its own.
// The pipeline always has priority.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   pipe_wr_en/num/data pipeline write-back request (never backpressured)
//   aux_valid/ready     aux result handshake; aux_num/aux_data carry the result
//   wr_en/num/data      registered register-file write
//   busy                per-register mask of aux writes pending in the FIFO
//   fifo_count          FIFO occupancy 0..DEPTH
//   pipe_stall          asks upstream to hold off pipe writes so the FIFO drains
//   waw_err             1-cycle pulse: a pipe write hit a register still busy
module wb_merge #(
    parameter int DEPTH      = 4,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipe_wr_en,
    input  logic [4:0]               pipe_wr_num,
    input  logic [DW-1:0]            pipe_wr_data,
    input  logic                     aux_valid,
    output logic                     aux_ready,
    input  logic [4:0]               aux_num,
    input  logic [DW-1:0]            aux_data,
    output logic                     wr_en,
    output logic [4:0]               wr_num,
    output logic [DW-1:0]            wr_data,
    output logic [31:0]              busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     pipe_stall,
    output logic                     waw_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic [DEPTH-1:0] slot_valid;
    logic [4:0]      num_mem  [DEPTH];
    logic [DW-1:0]   data_mem [DEPTH];
    logic [CW-1:0]   starve;

    logic pipe_req;
    logic push;
    logic pop;

    // Handshake and FIFO control. aux_ready depends on occupancy only, so a
    // full FIFO refuses a push even when a pop frees a slot the same cycle.
    always_comb begin
        pipe_req  = pipe_wr_en && (pipe_wr_num != '0);
        aux_ready = (count < FULL_CNT);
        // r0 results complete the handshake but are never stored.
        push      = aux_valid && aux_ready && (aux_num != '0);
        pop       = !pipe_req && (count != '0);
    end

    // Busy mask built from per-slot valid bits rather than pointer arithmetic.
    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (slot_valid[i]) begin
                busy[num_mem[i]] = 1'b1;
            end
        end
        busy[0] = 1'b0;
    end

    always_comb begin
        fifo_count = count;
        pipe_stall = (starve == STARVE_LIM);
    end

    // FIFO bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            slot_valid <= '0;
        end else begin
            if (push) begin
                wr_ptr             <= wr_ptr + 1'b1;
                slot_valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr             <= rd_ptr + 1'b1;
                slot_valid[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: slot_valid and count gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            num_mem[wr_ptr]  <= aux_num;
            data_mem[wr_ptr] <= aux_data;
        end
    end

    // Registered write port; wr_num/wr_data hold when nothing is written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_num  <= '0;
            wr_data <= '0;
            waw_err <= 1'b0;
        end else begin
            waw_err <= pipe_req && busy[pipe_wr_num];
            if (pipe_req) begin
                wr_en   <= 1'b1;
                wr_num  <= pipe_wr_num;
                wr_data <= pipe_wr_data;
            end else if (pop) begin
                wr_en   <= 1'b1;
                wr_num  <= num_mem[rd_ptr];
                wr_data <= data_mem[rd_ptr];
            end else begin
                wr_en   <= 1'b0;
            end
        end
    end

    // Counts cycles the FIFO head has waited; saturates at the stall threshold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve <= '0;
        end else if ((count == '0) || pop) begin
            starve <= '0;
        end else if (starve != STARVE_LIM) begin
            starve <= starve + 1'b1;
        end
    end

endmodule
